// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - ALU result bundle handshake interface
// Purpose: carries one ALU result bundle (op, two results, status,
// destination indices, flags write enable) with a valid/ready handshake.
// Modports:
//   master : upstream ALU side, drives the bundle and in_valid, sees in_ready
//   slave  : writeback side, receives the bundle and drives in_ready
interface alu_writeback_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_op;
    logic [DATA_W-1:0] in_q0;
    logic [DATA_W-1:0] in_q1;
    logic [3:0]        in_st;
    logic [REG_AW-1:0] in_rd0;
    logic [REG_AW-1:0] in_rd1;
    logic              in_flags_we;

    modport master (
        output in_valid, in_op, in_q0, in_q1, in_st, in_rd0, in_rd1, in_flags_we,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_q0, in_q1, in_st, in_rd0, in_rd1, in_flags_we,
        output in_ready
    );
endinterface

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback stage with flags and error tracking
// Purpose: accepts ALU result bundles and commits them to a single-port
// register file; MUL results are written low word then high word.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_if (slave)     : result bundle handshake (in_valid/in_ready + fields)
//   rf_we/waddr/wdata : register-file write port (registered)
//   flags_q           : architectural flags {N,Z,C,V}
//   err_illegal       : sticky illegal-opcode flag, err_clr clears it
//   busy              : high whenever the stage is not idle
module alu_writeback #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_writeback_if.slave    in_if,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        flags_q,
    output logic              err_illegal,
    input  logic              err_clr,
    output logic              busy
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MUL   = 8'h04;
    localparam logic [7:0] OP_LAST  = 8'h11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic [7:0]        op_q;
    logic [DATA_W-1:0] q0_q;
    logic [DATA_W-1:0] q1_q;
    logic [3:0]        st_q;
    logic [REG_AW-1:0] rd0_q;
    logic [REG_AW-1:0] rd1_q;
    logic              fwe_q;

    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              err_q;

    logic              xfer;
    logic              lo_dual;

    function automatic logic op_is_write(input logic [7:0] op);
        return (op != OP_NOP) && (op <= OP_LAST);
    endfunction

    function automatic logic op_is_illegal(input logic [7:0] op);
        return op > OP_LAST;
    endfunction

    // r0 is hardwired zero when ZERO_REG is set: the write is dropped but
    // the sequencing is unaffected.
    function automatic logic addr_blocked(input logic [REG_AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Ready depends on state only; a MUL in WR_LO must stall for its high word.
    assign in_if.in_ready = (state_q == IDLE) || ((state_q == WR_LO) && (op_q != OP_MUL));
    assign xfer           = in_if.in_valid && in_if.in_ready;
    assign lo_dual        = (state_q == WR_LO) && (op_q == OP_MUL);

    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            IDLE:    if (xfer) state_d = WR_LO;
            WR_LO: begin
                if (op_q == OP_MUL) state_d = WR_HI;
                else if (xfer)      state_d = WR_LO;
                else                state_d = IDLE;
            end
            WR_HI:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The write port is registered, so the write presented in the next
        // state is prepared here: either the low word of a bundle being
        // accepted now, or the high word following a MUL's low word. The two
        // cannot coincide because in_ready is low while a MUL sits in WR_LO.
        if (xfer && op_is_write(in_if.in_op)) begin
            rf_waddr_d = in_if.in_rd0;
            rf_wdata_d = in_if.in_q0;
            rf_we_d    = !addr_blocked(in_if.in_rd0);
        end else if (lo_dual) begin
            rf_waddr_d = rd1_q;
            rf_wdata_d = q1_q;
            rf_we_d    = !addr_blocked(rd1_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            q0_q       <= '0;
            q1_q       <= '0;
            st_q       <= '0;
            rd0_q      <= '0;
            rd1_q      <= '0;
            fwe_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;

            if (xfer) begin
                op_q  <= in_if.in_op;
                q0_q  <= in_if.in_q0;
                q1_q  <= in_if.in_q1;
                st_q  <= in_if.in_st;
                rd0_q <= in_if.in_rd0;
                rd1_q <= in_if.in_rd1;
                fwe_q <= in_if.in_flags_we;
            end

            // Flags update once per bundle, at the end of WR_LO only.
            if ((state_q == WR_LO) && fwe_q && op_is_write(op_q)) begin
                flags_q <= st_q;
            end

            // Setting takes priority over a simultaneous clear.
            if ((state_q == WR_LO) && op_is_illegal(op_q)) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign err_illegal = err_q;
    assign busy        = (state_q != IDLE);

    // rd0_q is kept for completeness of the captured bundle; the low-word
    // address is taken directly at capture time.
    logic unused_rd0;
    assign unused_rd0 = ^rd0_q ^ ^q0_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - self-checking bench for alu_writeback
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  flags_q;
    logic        err_illegal;
    logic        err_clr;
    logic        busy;

    int applied;
    int miscompares;
    int wr_count;

    alu_writeback_if #(.DATA_W(32), .REG_AW(5)) wbif ();

    alu_writeback #(.DATA_W(32), .REG_AW(5), .ZERO_REG(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (wbif.slave),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .flags_q     (flags_q),
        .err_illegal (err_illegal),
        .err_clr     (err_clr),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [3:0] m_flags;
    logic       m_err;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] q0;
        logic [31:0] q1;
        logic [3:0]  st;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic        fwe;
        int          nw;
        logic [3:0]  ef;
        logic        ee;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the register file and flags should see for each
    // accepted bundle, straight from the op class rules.
    task automatic model_accept(input logic [7:0] op, input logic [31:0] q0, q1,
                                input logic [3:0] st, input logic [4:0] rd0, rd1,
                                input logic fwe);
        wr_t w;
        if (op == 8'h00) return;
        if (op >= 8'h12) begin
            m_err = 1'b1;
            return;
        end
        if (rd0 != 0) begin w.a = rd0; w.d = q0; exp_q.push_back(w); end
        if (op == 8'h04 && rd1 != 0) begin w.a = rd1; w.d = q1; exp_q.push_back(w); end
        if (fwe) m_flags = st;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] q0, q1,
                         input logic [3:0] st, input logic [4:0] rd0, rd1, input logic fwe);
        wbif.in_valid    = 1'b1;
        wbif.in_op       = op;
        wbif.in_q0       = q0;
        wbif.in_q1       = q1;
        wbif.in_st       = st;
        wbif.in_rd0      = rd0;
        wbif.in_rd1      = rd1;
        wbif.in_flags_we = fwe;
    endtask

    task automatic put(input logic [7:0] op, input logic [31:0] q0, q1,
                       input logic [3:0] st, input logic [4:0] rd0, rd1, input logic fwe);
        int n;
        n = 0;
        @(negedge clk);
        drive(op, q0, q1, st, rd0, rd1, fwe);
        while (wbif.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            applied++;
            miscompares++;
            $display("FAIL put_timeout: in_ready %b required 1", wbif.in_ready);
        end else begin
            model_accept(op, q0, q1, st, rd0, rd1, fwe);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wbif.in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            applied++;
            miscompares++;
            $display("FAIL idle_timeout: busy %b required 0", busy);
        end
    endtask

    // Every committed write must be the next one the model expects.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            wr_t w;
            wr_count++;
            if (exp_q.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", rf_waddr, rf_wdata);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", {27'd0, rf_waddr}, {27'd0, w.a});
                chk("wr_data", rf_wdata, w.d);
            end
        end
    end

    initial begin
        applied = 0;
        miscompares = 0;
        wr_count = 0;
        m_flags = 4'h0;
        m_err = 1'b0;
        rst_n = 1'b0;
        err_clr = 1'b0;
        drive(8'h00, 0, 0, 4'h0, 5'd0, 5'd0, 1'b0);
        wbif.in_valid = 1'b0;

        //                op     q0           q1           st    rd0    rd1    fwe  nw ef    ee
        vt[0]  = '{8'h01, 32'h5,       32'h0,       4'h0, 5'd3,  5'd0,  1'b1, 1, 4'h0, 1'b0};
        vt[1]  = '{8'h04, 32'h1,       32'h2,       4'h2, 5'd4,  5'd5,  1'b1, 2, 4'h2, 1'b0};
        vt[2]  = '{8'h02, 32'h77,      32'h0,       4'h4, 5'd0,  5'd0,  1'b1, 0, 4'h4, 1'b0};
        vt[3]  = '{8'h00, 32'h99,      32'h0,       4'hF, 5'd8,  5'd0,  1'b1, 0, 4'h4, 1'b0};
        vt[4]  = '{8'h20, 32'h1,       32'h0,       4'h9, 5'd8,  5'd0,  1'b1, 0, 4'h4, 1'b1};
        vt[5]  = '{8'h11, 32'hAA,      32'h0,       4'h8, 5'd7,  5'd0,  1'b0, 1, 4'h4, 1'b0};
        vt[6]  = '{8'h12, 32'h3,       32'h0,       4'h1, 5'd7,  5'd0,  1'b1, 0, 4'h4, 1'b1};
        vt[7]  = '{8'h10, 32'hDEAD,    32'h0,       4'h1, 5'd31, 5'd0,  1'b1, 1, 4'h1, 1'b0};
        vt[8]  = '{8'h04, 32'h11,      32'h22,      4'hC, 5'd6,  5'd6,  1'b1, 2, 4'hC, 1'b0};
        vt[9]  = '{8'hFF, 32'h4,       32'h0,       4'h3, 5'd2,  5'd0,  1'b1, 0, 4'hC, 1'b1};
        vt[10] = '{8'h04, 32'h123,     32'h456,     4'hA, 5'd0,  5'd9,  1'b1, 1, 4'hA, 1'b0};
        vt[11] = '{8'h04, 32'h1,       32'h0,       4'h5, 5'd10, 5'd0,  1'b0, 1, 4'hA, 1'b0};
        vt[12] = '{8'h0D, 32'hF0F0,    32'h0,       4'h6, 5'd1,  5'd0,  1'b1, 1, 4'h6, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_rf_we", {31'd0, rf_we}, 0);
        chk("rst_waddr", {27'd0, rf_waddr}, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_flags", {28'd0, flags_q}, 0);
        chk("rst_err", {31'd0, err_illegal}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, wbif.in_ready}, 1);

        // Table: each bundle applied in isolation from IDLE.
        for (int i = 0; i < 13; i++) begin
            wr_count = 0;
            put(vt[i].op, vt[i].q0, vt[i].q1, vt[i].st, vt[i].rd0, vt[i].rd1, vt[i].fwe);
            idle(1);
            wait_idle();
            @(negedge clk);
            chk($sformatf("vec%0d_nwrites", i), wr_count, vt[i].nw);
            chk($sformatf("vec%0d_flags", i), {28'd0, flags_q}, {28'd0, vt[i].ef});
            chk($sformatf("vec%0d_err", i), {31'd0, err_illegal}, {31'd0, vt[i].ee});
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            m_err = 1'b0;
        end

        // ADD latency: write presented in the cycle right after transfer.
        put(8'h01, 32'h5, 32'h0, 4'h0, 5'd3, 5'd0, 1'b1);
        @(negedge clk);
        wbif.in_valid = 1'b0;
        chk("add_we", {31'd0, rf_we}, 1);
        chk("add_waddr", {27'd0, rf_waddr}, 3);
        chk("add_wdata", rf_wdata, 5);
        chk("add_busy", {31'd0, busy}, 1);
        @(negedge clk);
        chk("add_busy_after", {31'd0, busy}, 0);
        chk("add_we_after", {31'd0, rf_we}, 0);
        chk("add_flags", {28'd0, flags_q}, 0);

        // MUL with an ADD queued behind it, in_valid held high.
        put(8'h04, 32'h1, 32'h2, 4'h2, 5'd4, 5'd5, 1'b1);
        @(negedge clk);
        drive(8'h01, 32'h33, 32'h0, 4'h8, 5'd12, 5'd0, 1'b0);
        chk("mul_lo_ready", {31'd0, wbif.in_ready}, 0);
        chk("mul_lo_we", {31'd0, rf_we}, 1);
        chk("mul_lo_addr", {27'd0, rf_waddr}, 4);
        @(negedge clk);
        chk("mul_hi_ready", {31'd0, wbif.in_ready}, 0);
        chk("mul_hi_we", {31'd0, rf_we}, 1);
        chk("mul_hi_addr", {27'd0, rf_waddr}, 5);
        chk("mul_hi_data", rf_wdata, 2);
        chk("mul_hi_busy", {31'd0, busy}, 1);
        @(negedge clk);
        chk("mul_after_ready", {31'd0, wbif.in_ready}, 1);
        chk("mul_flags", {28'd0, flags_q}, 4'h2);
        model_accept(8'h01, 32'h33, 32'h0, 4'h8, 5'd12, 5'd0, 1'b0);
        @(negedge clk);
        wbif.in_valid = 1'b0;
        chk("queued_add_addr", {27'd0, rf_waddr}, 12);
        wait_idle();

        // Three back-to-back ORs.
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive(8'h0D, 32'h100 + i, 32'h0, 4'h0, i[4:0], 5'd0, 1'b0);
            chk("or_ready", {31'd0, wbif.in_ready}, 1);
            model_accept(8'h0D, 32'h100 + i, 32'h0, 4'h0, i[4:0], 5'd0, 1'b0);
            if (i > 1) begin
                chk("or_we", {31'd0, rf_we}, 1);
                chk("or_addr", {27'd0, rf_waddr}, i - 1);
            end
        end
        @(negedge clk);
        wbif.in_valid = 1'b0;
        chk("or_we_last", {31'd0, rf_we}, 1);
        chk("or_addr_last", {27'd0, rf_waddr}, 3);
        wait_idle();

        // Illegal op accepted while err_clr is asserted: set wins.
        put(8'h30, 0, 0, 4'h0, 5'd1, 5'd0, 1'b1);
        idle(1);
        wait_idle();
        chk("err_sticky", {31'd0, err_illegal}, 1);
        @(negedge clk);
        drive(8'h40, 0, 0, 4'hF, 5'd2, 5'd0, 1'b1);
        err_clr = 1'b1;
        model_accept(8'h40, 0, 0, 4'hF, 5'd2, 5'd0, 1'b1);
        @(negedge clk);
        wbif.in_valid = 1'b0;
        chk("err_cleared_first", {31'd0, err_illegal}, 0);
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_set_wins", {31'd0, err_illegal}, 1);
        chk("err_flags_kept", {28'd0, flags_q}, 4'h2);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_clear", {31'd0, err_illegal}, 0);

        // Reset during WR_HI of a MUL.
        put(8'h04, 32'h7, 32'h8, 4'hF, 5'd11, 5'd12, 1'b1);
        idle(1);
        @(negedge clk);
        chk("rst_hi_we", {31'd0, rf_we}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_we", {31'd0, rf_we}, 0);
        chk("rst_async_busy", {31'd0, busy}, 0);
        chk("rst_async_ready", {31'd0, wbif.in_ready}, 1);
        chk("rst_async_flags", {28'd0, flags_q}, 0);
        exp_q.delete();
        m_flags = 4'h0;
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_count = 0;
        idle(3);
        chk("rst_no_hi_write", wr_count, 0);

        // Randomised bundles against the model.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] op;
            r = $urandom_range(0, 9);
            if (r == 0)               op = 8'h00;
            else if (r <= 2)          op = 8'h04;
            else if (r == 3)          op = 8'($urandom_range(8'h12, 8'hFF));
            else                      op = 8'($urandom_range(1, 8'h11));
            put(op, $urandom, $urandom, 4'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
        wait_idle();
        @(negedge clk);
        chk("rand_flags", {28'd0, flags_q}, {28'd0, m_flags});
        chk("rand_err", {31'd0, err_illegal}, {31'd0, m_err});
        chk("rand_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
